// File: rtl/pipe_skid_stage_pkg.sv
// Shared constants for the inter-stage pipeline register: control encodings
// and occupancy codes used by pipe_skid_stage.
package pipe_skid_stage_pkg;

  localparam logic       FLUSH_ACT = 1'b1;
  localparam logic       RST_ACT   = 1'b0;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_stage.sv
// Inter-stage pipeline register with valid/allowin handshake. SKID_EN selects a
// single-entry register or a two-entry skid buffer whose allowin is registered.
module pipe_skid_stage
  import pipe_skid_stage_pkg::*;
#(
  parameter int DATA_W    = 64,
  parameter int SKID_EN   = 0,
  parameter int FLUSH_CLR = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_flush,
  input  logic              up_valid,
  output logic              up_allowin,
  input  logic [DATA_W-1:0] up_data,
  input  logic              ready_go,
  input  logic              dn_allowin,
  output logic              dn_valid,
  output logic [DATA_W-1:0] dn_data,
  output logic              stage_valid,
  output logic [1:0]        occ
);

  logic              w_flush;
  logic              w_push;
  logic              w_pop;
  logic              w_allowin;
  logic              w_stage_valid;
  logic [1:0]        w_occ;
  logic [DATA_W-1:0] w_head;

  assign w_flush     = (pipe_flush == FLUSH_ACT);
  assign w_push      = up_valid && w_allowin;
  assign w_pop       = dn_valid && dn_allowin;

  assign up_allowin  = w_allowin;
  assign stage_valid = w_stage_valid;
  assign occ         = w_occ;
  assign dn_data     = w_head;
  assign dn_valid    = w_stage_valid && ready_go;

  generate
    if (SKID_EN == 0) begin : g_single
      logic              r_valid;
      logic [DATA_W-1:0] r_head;

      // allowin looks through to downstream so a full register can still stream
      assign w_allowin     = !r_valid || (ready_go && dn_allowin);
      assign w_stage_valid = r_valid;
      assign w_occ         = {1'b0, r_valid};
      assign w_head        = r_head;

      // Head register: flush wins over push/pop
      always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACT) begin
          r_valid <= 1'b0;
          r_head  <= '0;
        end else if (w_flush) begin
          r_valid <= 1'b0;
          if (FLUSH_CLR != 0) begin
            r_head <= '0;
          end
        end else begin
          r_valid <= w_push || (r_valid && !w_pop);
          if (w_push) begin
            r_head <= up_data;
          end
        end
      end
    end else begin : g_skid
      logic [1:0]        r_occ;
      logic [DATA_W-1:0] r_head;
      logic [DATA_W-1:0] r_skid;
      logic [1:0]        w_occ_nxt;
      logic [DATA_W-1:0] w_head_nxt;
      logic [DATA_W-1:0] w_skid_nxt;

      // allowin depends only on registered occupancy, breaking the ready path
      assign w_allowin     = (r_occ != OCC_FULL);
      assign w_stage_valid = (r_occ != OCC_EMPTY);
      assign w_occ         = r_occ;
      assign w_head        = r_head;

      // Next-state for occupancy and the two payload registers
      always_comb begin
        w_occ_nxt  = r_occ;
        w_head_nxt = r_head;
        w_skid_nxt = r_skid;
        if (w_flush) begin
          w_occ_nxt = OCC_EMPTY;
          if (FLUSH_CLR != 0) begin
            w_head_nxt = '0;
            w_skid_nxt = '0;
          end else begin
            w_head_nxt = r_head;
          end
        end else begin
          case (r_occ)
            OCC_EMPTY: begin
              if (w_push) begin
                w_head_nxt = up_data;
                w_occ_nxt  = OCC_ONE;
              end else begin
                w_occ_nxt  = OCC_EMPTY;
              end
            end
            OCC_ONE: begin
              if (w_push && !w_pop) begin
                w_skid_nxt = up_data;
                w_occ_nxt  = OCC_FULL;
              end else if (w_push && w_pop) begin
                w_head_nxt = up_data;
              end else if (w_pop) begin
                w_occ_nxt  = OCC_EMPTY;
              end else begin
                w_occ_nxt  = OCC_ONE;
              end
            end
            OCC_FULL: begin
              if (w_pop) begin
                w_head_nxt = r_skid;
                w_occ_nxt  = OCC_ONE;
              end else begin
                w_occ_nxt  = OCC_FULL;
              end
            end
            default: begin
              w_occ_nxt = OCC_EMPTY;
            end
          endcase
        end
      end

      // State registers
      always_ff @(posedge clk or negedge rst_n) begin
        if (rst_n == RST_ACT) begin
          r_occ  <= OCC_EMPTY;
          r_head <= '0;
          r_skid <= '0;
        end else begin
          r_occ  <= w_occ_nxt;
          r_head <= w_head_nxt;
          r_skid <= w_skid_nxt;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Directed and randomized checks for pipe_skid_stage in single-entry mode (a_),
// skid mode with flush-clear (b_) and skid mode holding payload on flush (c_).
module tb_pipe_skid_stage;

  localparam int W = 64;

  logic         clk;
  logic         rst_n;
  int           n_tests;
  int           n_fail;

  logic         a_flush, a_up_valid, a_ready_go, a_dn_allowin;
  logic [W-1:0] a_up_data;
  logic         a_up_allowin, a_dn_valid, a_stage_valid;
  logic [W-1:0] a_dn_data;
  logic [1:0]   a_occ;

  logic         b_flush, b_up_valid, b_ready_go, b_dn_allowin;
  logic [W-1:0] b_up_data;
  logic         b_up_allowin, b_dn_valid, b_stage_valid;
  logic [W-1:0] b_dn_data;
  logic [1:0]   b_occ;

  logic         c_up_allowin, c_dn_valid, c_stage_valid;
  logic [W-1:0] c_dn_data;
  logic [1:0]   c_occ;

  pipe_skid_stage #(.DATA_W(W), .SKID_EN(0), .FLUSH_CLR(1)) u_a (
    .clk(clk), .rst_n(rst_n), .pipe_flush(a_flush),
    .up_valid(a_up_valid), .up_allowin(a_up_allowin), .up_data(a_up_data),
    .ready_go(a_ready_go), .dn_allowin(a_dn_allowin), .dn_valid(a_dn_valid),
    .dn_data(a_dn_data), .stage_valid(a_stage_valid), .occ(a_occ)
  );

  pipe_skid_stage #(.DATA_W(W), .SKID_EN(1), .FLUSH_CLR(1)) u_b (
    .clk(clk), .rst_n(rst_n), .pipe_flush(b_flush),
    .up_valid(b_up_valid), .up_allowin(b_up_allowin), .up_data(b_up_data),
    .ready_go(b_ready_go), .dn_allowin(b_dn_allowin), .dn_valid(b_dn_valid),
    .dn_data(b_dn_data), .stage_valid(b_stage_valid), .occ(b_occ)
  );

  pipe_skid_stage #(.DATA_W(W), .SKID_EN(1), .FLUSH_CLR(0)) u_c (
    .clk(clk), .rst_n(rst_n), .pipe_flush(b_flush),
    .up_valid(b_up_valid), .up_allowin(c_up_allowin), .up_data(b_up_data),
    .ready_go(b_ready_go), .dn_allowin(b_dn_allowin), .dn_valid(c_dn_valid),
    .dn_data(c_dn_data), .stage_valid(c_stage_valid), .occ(c_occ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] sb[$];
  logic [W-1:0] seq;
  logic         s_push, s_pop;

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    a_flush = 1'b0; a_up_valid = 1'b0; a_ready_go = 1'b1; a_dn_allowin = 1'b1; a_up_data = '0;
    b_flush = 1'b0; b_up_valid = 1'b0; b_ready_go = 1'b1; b_dn_allowin = 1'b1; b_up_data = '0;
    #1;
    check_val("rst_a_valid",   {63'd0, a_stage_valid}, 64'd0);
    check_val("rst_a_dnvalid", {63'd0, a_dn_valid},    64'd0);
    check_val("rst_a_allowin", {63'd0, a_up_allowin},  64'd1);
    check_val("rst_a_data",    a_dn_data,              64'd0);
    check_val("rst_b_occ",     {62'd0, b_occ},         64'd0);
    check_val("rst_b_allowin", {63'd0, b_up_allowin},  64'd1);
    check_val("rst_b_data",    b_dn_data,              64'd0);
    #11 rst_n = 1'b1;
    tick();

    // Streaming through the single-entry register, one cycle of latency
    for (int i = 1; i <= 8; i++) begin
      a_up_valid = 1'b1;
      a_up_data  = W'(i);
      tick();
      check_val($sformatf("stream_data_%0d", i), a_dn_data, W'(i));
      check_val($sformatf("stream_vld_%0d", i), {63'd0, a_dn_valid}, 64'd1);
    end
    a_up_valid = 1'b0;
    tick();
    check_val("stream_drained", {63'd0, a_stage_valid}, 64'd0);

    // Load-use stall: head held, later offer not accepted
    a_up_valid = 1'b1; a_up_data = 64'hA; a_ready_go = 1'b0;
    tick();
    a_up_data = 64'hB;
    for (int i = 0; i < 2; i++) begin
      check_val("lu_dnvalid", {63'd0, a_dn_valid},   64'd0);
      check_val("lu_allowin", {63'd0, a_up_allowin}, 64'd0);
      check_val("lu_data",    a_dn_data,             64'hA);
      tick();
    end
    a_ready_go = 1'b1;
    #1;
    check_val("lu_release_vld", {63'd0, a_dn_valid},   64'd1);
    check_val("lu_release_dat", a_dn_data,             64'hA);
    check_val("lu_release_aw",  {63'd0, a_up_allowin}, 64'd1);
    tick();
    check_val("lu_next_data", a_dn_data, 64'hB);
    a_up_valid = 1'b0;
    tick();
    check_val("lu_empty", {63'd0, a_stage_valid}, 64'd0);

    // Flush on the single-entry register drops the concurrent push
    a_up_valid = 1'b1; a_up_data = 64'h77;
    tick();
    a_flush = 1'b1; a_up_data = 64'h78;
    tick();
    check_val("a_flush_valid", {63'd0, a_stage_valid}, 64'd0);
    check_val("a_flush_data",  a_dn_data,              64'd0);
    a_flush = 1'b0; a_up_valid = 1'b0;
    tick();

    // Skid fill under back-pressure, then in-order drain
    b_dn_allowin = 1'b0;
    b_up_valid = 1'b1; b_up_data = 64'h11;
    tick();
    check_val("skid_occ1",     {62'd0, b_occ},        64'd1);
    check_val("skid_d1",       b_dn_data,             64'h11);
    check_val("skid_aw1",      {63'd0, b_up_allowin}, 64'd1);
    b_up_data = 64'h22;
    tick();
    check_val("skid_occ2",     {62'd0, b_occ},        64'd2);
    check_val("skid_aw2",      {63'd0, b_up_allowin}, 64'd0);
    check_val("skid_hold",     b_dn_data,             64'h11);
    b_up_valid = 1'b0; b_dn_allowin = 1'b1;
    tick();
    check_val("skid_pop1",     b_dn_data,             64'h22);
    check_val("skid_pop1_aw",  {63'd0, b_up_allowin}, 64'd1);
    check_val("skid_pop1_occ", {62'd0, b_occ},        64'd1);
    tick();
    check_val("skid_empty",    {63'd0, b_dn_valid},   64'd0);

    // Full-rate streaming through the skid buffer
    for (int i = 1; i <= 4; i++) begin
      b_up_valid = 1'b1;
      b_up_data  = 64'h100 + W'(i);
      tick();
      check_val($sformatf("skid_stream_%0d", i), b_dn_data, 64'h100 + W'(i));
      check_val($sformatf("skid_stream_occ_%0d", i), {62'd0, b_occ}, 64'd1);
    end
    b_up_valid = 1'b0;
    tick();

    // Flush with occ=2 and a concurrent offer
    b_dn_allowin = 1'b0;
    b_up_valid = 1'b1; b_up_data = 64'h31;
    tick();
    b_up_data = 64'h32;
    tick();
    check_val("fl_pre_occ", {62'd0, b_occ}, 64'd2);
    b_flush = 1'b1; b_up_data = 64'h33;
    tick();
    check_val("fl_occ",      {62'd0, b_occ},      64'd0);
    check_val("fl_dnvalid",  {63'd0, b_dn_valid}, 64'd0);
    check_val("fl_head_clr", b_dn_data,           64'd0);
    check_val("fl_c_occ",    {62'd0, c_occ},      64'd0);
    check_val("fl_c_hold",   c_dn_data,           64'h31);
    b_flush = 1'b0; b_up_valid = 1'b0; b_dn_allowin = 1'b1;
    tick();
    check_val("fl_no33", {63'd0, b_dn_valid}, 64'd0);
    b_up_valid = 1'b1; b_up_data = 64'h34;
    tick();
    b_flush = 1'b1; b_up_data = 64'h35;
    tick();
    check_val("fl1_occ",    {62'd0, b_occ}, 64'd0);
    check_val("fl1_c_hold", c_dn_data,      64'h34);
    b_flush = 1'b0; b_up_valid = 1'b0;
    tick();

    // Async reset between edges with entries held
    b_dn_allowin = 1'b0; b_up_valid = 1'b1; b_up_data = 64'h40;
    a_dn_allowin = 1'b0; a_up_valid = 1'b1; a_up_data = 64'h41;
    tick();
    check_val("ar_pre_occ", {62'd0, b_occ}, 64'd1);
    b_up_valid = 1'b0; a_up_valid = 1'b0;
    #3 rst_n = 1'b0;
    #1;
    check_val("ar_b_valid",   {63'd0, b_stage_valid}, 64'd0);
    check_val("ar_b_occ",     {62'd0, b_occ},         64'd0);
    check_val("ar_b_allowin", {63'd0, b_up_allowin},  64'd1);
    check_val("ar_b_data",    b_dn_data,              64'd0);
    check_val("ar_a_valid",   {63'd0, a_stage_valid}, 64'd0);
    b_up_valid = 1'b1; b_up_data = 64'h44; b_dn_allowin = 1'b1; a_dn_allowin = 1'b1;
    #2 rst_n = 1'b1;
    tick();
    check_val("ar_push_vld",  {63'd0, b_dn_valid}, 64'd1);
    check_val("ar_push_data", b_dn_data,           64'h44);
    b_up_valid = 1'b0;
    tick();
    check_val("ar_drained", {62'd0, b_occ}, 64'd0);

    // Random back-pressure against a queue scoreboard, then drain
    seq = 64'h1000;
    for (int c = 0; c < 1010; c++) begin
      if (c < 1000) begin
        b_up_valid   = 1'($urandom_range(0, 1));
        b_dn_allowin = 1'($urandom_range(0, 1));
        b_ready_go   = 1'($urandom_range(0, 3) != 0);
      end else begin
        b_up_valid = 1'b0; b_dn_allowin = 1'b1; b_ready_go = 1'b1;
      end
      b_up_data = seq;
      #1;
      check_val("rnd_occ", {62'd0, b_occ}, W'(sb.size()));
      check_val("rnd_occ_max", {63'd0, (b_occ <= 2'd2)}, 64'd1);
      s_push = b_up_valid && b_up_allowin;
      s_pop  = b_dn_valid && b_dn_allowin;
      if (s_pop) begin
        if (sb.size() == 0) begin
          check_val("rnd_pop_empty", b_dn_data, 64'hDEAD);
        end else begin
          check_val("rnd_data", b_dn_data, sb.pop_front());
        end
      end
      if (s_push) begin
        sb.push_back(seq);
        seq = seq + 64'd1;
      end
      tick();
    end
    check_val("rnd_no_loss", W'(sb.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
